// File: rtl/clk_diag_decode.sv
// clk_diag_decode: CLK-module diagnostic-function receiver.
// Turns EBUS diag functions (ds code + strobe + RH data) into clock-control state.
// Ports:
//   clk, crobar_e_h        clock, synchronous active-high reset
//   ebus_ds                diag function code (7 bits, octal encoded)
//   ebus_diag_strobe       diag strobe, held >= 2 cycles per function
//   ebus_data_rh           EBUS data[18:35]; bit 0 = data35, only [3:0] (data[32:35]) used
//   a_change_coming        MBOX phase-change-coming qualifier for conditional step
//   clk_run .. diag_ack    registered clock-control outputs (see port list)
module clk_diag_decode #(
    parameter int unsigned BURST_W   = 8,
    parameter int unsigned DISABLE_W = 4
) (
    input  logic                 clk,
    input  logic                 crobar_e_h,
    input  logic [6:0]           ebus_ds,
    input  logic                 ebus_diag_strobe,
    input  logic [17:0]          ebus_data_rh,
    input  logic                 a_change_coming,
    output logic                 clk_run,
    output logic                 ebox_clk_en,
    output logic                 burst_busy,
    output logic [BURST_W-1:0]   burst_ctr,
    output logic [1:0]           clk_src,
    output logic [1:0]           clk_rate,
    output logic [DISABLE_W-1:0] ebox_clk_dis,
    output logic                 mr_reset,
    output logic                 ebox_run,
    output logic                 diag_ack
);

    localparam logic [6:0] DS_STOP_CLOCK  = 7'o000;
    localparam logic [6:0] DS_START_CLOCK = 7'o001;
    localparam logic [6:0] DS_STEP_CLOCK  = 7'o002;
    localparam logic [6:0] DS_COND_STEP   = 7'o004;
    localparam logic [6:0] DS_BURST       = 7'o005;
    localparam logic [6:0] DS_CLR_RESET   = 7'o006;
    localparam logic [6:0] DS_SET_RESET   = 7'o007;
    localparam logic [6:0] DS_CLR_RUN     = 7'o010;
    localparam logic [6:0] DS_SET_RUN     = 7'o011;
    localparam logic [6:0] DS_LOAD_RH     = 7'o042;
    localparam logic [6:0] DS_LOAD_LH     = 7'o043;
    localparam logic [6:0] DS_SRC_RATE    = 7'o044;
    localparam logic [6:0] DS_CLK_DIS     = 7'o045;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        BURST
    } state_t;

    state_t     state;
    logic       s_q;
    logic       cmd_valid;
    logic [6:0] cmd_ds;
    logic [3:0] cmd_data;
    logic       strobe_rise;
    logic       unused_data;

    assign strobe_rise = ebus_diag_strobe & ~s_q;
    assign unused_data = ^ebus_data_rh[17:4];

    // Capture on the strobe rising edge, act one cycle later; later assignments override
    // the per-state defaults so commands take priority over burst/step sequencing.
    always_ff @(posedge clk) begin
        if (crobar_e_h) begin
            state        <= IDLE;
            s_q          <= 1'b1;   // a strobe still high at reset release is not an edge
            cmd_valid    <= 1'b0;
            cmd_ds       <= 7'o000;
            cmd_data     <= 4'h0;
            clk_run      <= 1'b0;
            ebox_clk_en  <= 1'b0;
            burst_busy   <= 1'b0;
            burst_ctr    <= '0;
            clk_src      <= 2'b00;
            clk_rate     <= 2'b00;
            ebox_clk_dis <= '0;
            mr_reset     <= 1'b1;
            ebox_run     <= 1'b0;
            diag_ack     <= 1'b0;
        end else begin
            s_q       <= ebus_diag_strobe;
            cmd_valid <= strobe_rise;
            diag_ack  <= 1'b0;
            if (strobe_rise) begin
                cmd_ds   <= ebus_ds;
                cmd_data <= ebus_data_rh[3:0];
            end

            // Sequencing when no command intervenes
            case (state)
                STEP: begin
                    state       <= IDLE;
                    ebox_clk_en <= clk_run;
                end
                BURST: begin
                    if (burst_ctr == '0) begin
                        state       <= IDLE;
                        burst_busy  <= 1'b0;
                        ebox_clk_en <= clk_run;
                    end else begin
                        burst_ctr   <= burst_ctr - BURST_W'(1);
                        ebox_clk_en <= 1'b1;
                    end
                end
                default: ebox_clk_en <= clk_run;
            endcase

            if (cmd_valid) begin
                diag_ack <= 1'b1;
                case (cmd_ds)
                    DS_STOP_CLOCK, DS_START_CLOCK: begin
                        // Either one aborts a burst; the counter keeps its residual
                        clk_run     <= (cmd_ds == DS_START_CLOCK);
                        ebox_clk_en <= (cmd_ds == DS_START_CLOCK);
                        state       <= IDLE;
                        burst_busy  <= 1'b0;
                        burst_ctr   <= burst_ctr;
                    end
                    DS_STEP_CLOCK, DS_COND_STEP: begin
                        if (state == IDLE && !clk_run &&
                            (cmd_ds == DS_STEP_CLOCK || a_change_coming)) begin
                            state       <= STEP;
                            ebox_clk_en <= 1'b1;
                        end
                    end
                    DS_BURST: begin
                        // First enable cycle counts against the load value
                        if (state == IDLE && !clk_run && burst_ctr != '0) begin
                            state       <= BURST;
                            burst_busy  <= 1'b1;
                            ebox_clk_en <= 1'b1;
                            burst_ctr   <= burst_ctr - BURST_W'(1);
                        end
                    end
                    DS_CLR_RESET: mr_reset <= 1'b0;
                    DS_SET_RESET: mr_reset <= 1'b1;
                    DS_CLR_RUN:   ebox_run <= 1'b0;
                    DS_SET_RUN:   ebox_run <= 1'b1;
                    DS_LOAD_RH: begin
                        if (state != BURST) burst_ctr[3:0] <= cmd_data;
                    end
                    DS_LOAD_LH: begin
                        if (state != BURST) burst_ctr[7:4] <= cmd_data;
                    end
                    DS_SRC_RATE: begin
                        clk_src  <= cmd_data[3:2];
                        clk_rate <= cmd_data[1:0];
                    end
                    DS_CLK_DIS: ebox_clk_dis <= DISABLE_W'(cmd_data);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_diag_decode.sv
// tb_clk_diag_decode: directed-vector bench for clk_diag_decode.
module tb_clk_diag_decode;

    logic        clk = 1'b0;
    logic        crobar_e_h;
    logic [6:0]  ebus_ds;
    logic        ebus_diag_strobe;
    logic [17:0] ebus_data_rh;
    logic        a_change_coming;
    logic        clk_run;
    logic        ebox_clk_en;
    logic        burst_busy;
    logic [7:0]  burst_ctr;
    logic [1:0]  clk_src;
    logic [1:0]  clk_rate;
    logic [3:0]  ebox_clk_dis;
    logic        mr_reset;
    logic        ebox_run;
    logic        diag_ack;

    int vectors = 0;
    int miscompares = 0;

    clk_diag_decode #(.BURST_W(8), .DISABLE_W(4)) dut (
        .clk              (clk),
        .crobar_e_h       (crobar_e_h),
        .ebus_ds          (ebus_ds),
        .ebus_diag_strobe (ebus_diag_strobe),
        .ebus_data_rh     (ebus_data_rh),
        .a_change_coming  (a_change_coming),
        .clk_run          (clk_run),
        .ebox_clk_en      (ebox_clk_en),
        .burst_busy       (burst_busy),
        .burst_ctr        (burst_ctr),
        .clk_src          (clk_src),
        .clk_rate         (clk_rate),
        .ebox_clk_dis     (ebox_clk_dis),
        .mr_reset         (mr_reset),
        .ebox_run         (ebox_run),
        .diag_ack         (diag_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One function: a low cycle, then strobe held across capture and action edges.
    // Returns just after the action edge with the strobe dropped.
    task automatic issue(input logic [6:0] ds, input logic [3:0] d);
        ebus_diag_strobe = 1'b0;
        tick();
        ebus_ds          = ds;
        ebus_data_rh     = {14'h0, d};
        ebus_diag_strobe = 1'b1;
        tick();
        tick();
        check($sformatf("ack_%0o", ds), 32'(diag_ack), 32'd1);
        ebus_diag_strobe = 1'b0;
    endtask

    initial begin
        int cnt;
        int gap;
        logic seen_low;

        crobar_e_h       = 1'b1;
        ebus_ds          = 7'o000;
        ebus_diag_strobe = 1'b0;
        ebus_data_rh     = 18'h0;
        a_change_coming  = 1'b0;
        repeat (3) tick();
        crobar_e_h = 1'b0;

        // Reset state held for 20 idle cycles: {clk_run,en,busy,ctr,src,rate,dis,mr,run,ack}
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({clk_run, ebox_clk_en, burst_busy, burst_ctr, clk_src, clk_rate,
                 ebox_clk_dis, mr_reset, ebox_run, diag_ack} != {19'h0, 1'b1, 2'b00})
                cnt++;
        end
        check("reset_idle_bad_cycles", 32'(cnt), 32'd0);
        check("reset_mr_reset", 32'(mr_reset), 32'd1);

        // Burst of 0x13 = 19 cycles
        issue(7'o043, 4'd1);
        issue(7'o042, 4'd3);
        check("burst_ctr_load", 32'(burst_ctr), 32'h13);
        issue(7'o005, 4'd0);
        cnt = 0; gap = 0; seen_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ebox_clk_en) begin
                cnt++;
                if (seen_low) gap = 1;
            end else begin
                seen_low = 1'b1;
            end
            tick();
        end
        check("burst_en_cycles", 32'(cnt), 32'd19);
        check("burst_contiguous", 32'(gap), 32'd0);
        check("burst_busy_done", 32'(burst_busy), 32'd0);
        check("burst_ctr_done", 32'(burst_ctr), 32'd0);

        // Conditional step without and with phase-change-coming
        a_change_coming = 1'b0;
        issue(7'o004, 4'd0);
        check("cstep0_en", 32'(ebox_clk_en), 32'd0);
        tick();
        check("cstep0_en_late", 32'(ebox_clk_en), 32'd0);
        a_change_coming = 1'b1;
        issue(7'o004, 4'd0);
        check("cstep1_en", 32'(ebox_clk_en), 32'd1);
        tick();
        check("cstep1_en_off", 32'(ebox_clk_en), 32'd0);
        a_change_coming = 1'b0;
        issue(7'o002, 4'd0);
        check("step_en", 32'(ebox_clk_en), 32'd1);
        tick();
        check("step_en_off", 32'(ebox_clk_en), 32'd0);

        // Source/rate, disables, reset and run flops
        issue(7'o044, 4'b1011);
        check("clk_src", 32'(clk_src), 32'd2);
        check("clk_rate", 32'(clk_rate), 32'd3);
        issue(7'o045, 4'b0101);
        check("ebox_clk_dis", 32'(ebox_clk_dis), 32'h5);
        issue(7'o006, 4'd0);
        check("mr_reset_clr", 32'(mr_reset), 32'd0);
        issue(7'o011, 4'd0);
        check("ebox_run_set", 32'(ebox_run), 32'd1);
        issue(7'o010, 4'd0);
        check("ebox_run_clr", 32'(ebox_run), 32'd0);
        issue(7'o077, 4'hF);
        check("unknown_no_change", 32'({clk_src, clk_rate, ebox_clk_dis, mr_reset, clk_run}),
              32'({2'd2, 2'd3, 4'h5, 1'b0, 1'b0}));

        // START held 10 cycles: acted on once
        tick();
        ebus_ds          = 7'o001;
        ebus_diag_strobe = 1'b1;
        tick();
        check("start_not_yet", 32'(clk_run), 32'd0);
        tick();
        check("start_clk_run", 32'(clk_run), 32'd1);
        check("start_ack", 32'(diag_ack), 32'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (diag_ack) cnt++;
        end
        ebus_diag_strobe = 1'b0;
        check("start_extra_acks", 32'(cnt), 32'd0);
        check("run_en", 32'(ebox_clk_en), 32'd1);

        // Step while running: no state change; then STOP
        issue(7'o002, 4'd0);
        tick();
        check("step_while_run_en", 32'(ebox_clk_en), 32'd1);
        issue(7'o000, 4'd0);
        check("stop_clk_run", 32'(clk_run), 32'd0);
        check("stop_en", 32'(ebox_clk_en), 32'd0);

        // Burst of 10 aborted by STOP
        issue(7'o043, 4'd0);
        issue(7'o042, 4'hA);
        issue(7'o005, 4'd0);
        check("abort_busy_start", 32'(burst_busy), 32'd1);
        check("abort_ctr_start", 32'(burst_ctr), 32'd9);
        repeat (3) tick();
        issue(7'o000, 4'd0);
        check("abort_busy", 32'(burst_busy), 32'd0);
        check("abort_ctr", 32'(burst_ctr), 32'd4);
        check("abort_clk_run", 32'(clk_run), 32'd0);
        repeat (3) tick();
        check("abort_en_after", 32'(ebox_clk_en), 32'd0);
        check("abort_ctr_holds", 32'(burst_ctr), 32'd4);

        // Burst with zero count is ignored
        issue(7'o042, 4'd0);
        issue(7'o005, 4'd0);
        check("burst0_busy", 32'(burst_busy), 32'd0);
        check("burst0_en", 32'(ebox_clk_en), 32'd0);

        // Reset while strobe high; strobe still high after release is not acted on
        tick();
        ebus_ds          = 7'o001;
        ebus_diag_strobe = 1'b1;
        crobar_e_h       = 1'b1;
        tick();
        tick();
        crobar_e_h = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clk_run || diag_ack) cnt++;
        end
        ebus_diag_strobe = 1'b0;
        check("rst_strobe_ignored", 32'(cnt), 32'd0);
        check("rst_mr_reset", 32'(mr_reset), 32'd1);
        check("rst_clk_src", 32'(clk_src), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
